// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for three 4-digit common-anode
// 7-segment displays (solar, greenhouse, geothermal).
// New display values arrive through a valid/ready handshake into a pending
// buffer. They are promoted to the active set only at a frame boundary, so
// one frame never mixes old and new digits. Each digit slot starts with a
// blanking dead-time (all anodes off) in which the segment bus is
// re-loaded. The anode then stays on for SCAN_DIV cycles.

module seg7_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] solar_val,
  input  logic [15:0] greenhouse_val,
  input  logic [15:0] geothermal_val,
  input  logic        lz_blank,
  output logic [3:0]  solar_anode_en,
  output logic [3:0]  greenhouse_anode_en,
  output logic [3:0]  geothermal_anode_en,
  output logic [6:0]  solar_seg,
  output logic [6:0]  greenhouse_seg,
  output logic [6:0]  geothermal_seg
);

  // Scan phases: DEAD = all anodes off (segments may change), ON = one anode lit.
  localparam logic ST_DEAD = 1'b0;
  localparam logic ST_ON   = 1'b1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  // Scan sequencer state
  logic             r_state;
  logic [1:0]       r_digit;
  logic [CNT_W-1:0] r_cnt;
  logic             w_state_next;
  logic [1:0]       w_digit_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_frame_end;

  // Handshake / double-buffer control
  logic r_pend_full;
  logic r_pend_lz;
  logic r_act_lz;
  logic r_load_ready;
  logic w_load_accept;
  logic w_swap;
  logic w_pend_full_next;
  logic w_act_lz_next;

  // Registered anode enable, shared by all three displays
  logic [3:0] r_anode;

  // Per-display data, index 0 = solar, 1 = greenhouse, 2 = geothermal
  logic [2:0][15:0] w_in_val;
  logic [2:0][6:0]  w_seg;

  assign w_in_val = {geothermal_val, greenhouse_val, solar_val};

  // Nibble-to-segment decode for one digit position, including
  // leading-zero suppression: digits 3..1 go dark when they and every
  // higher nibble are zero. Digit 0 always shows so a zero value reads "0".
  function automatic logic [6:0] f_digit_seg(
    input logic [15:0] val,
    input logic        lz,
    input logic [1:0]  dig
  );
    logic [3:0]  nib;
    logic [15:0] upper;
    logic [6:0]  pat;
    nib   = val[{dig, 2'b00} +: 4];
    upper = val >> {dig, 2'b00};
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    if (lz && (dig != 2'd0) && (upper == 16'd0)) begin
      pat = 7'h00;
    end
    return pat;
  endfunction

  // Next-state logic for the DEAD/ON phase sequencer and digit rotation.
  always_comb begin
    w_state_next = r_state;
    w_digit_next = r_digit;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_frame_end  = 1'b0;
    case (r_state)
      ST_DEAD: begin
        if (r_cnt == DEAD_LAST) begin
          w_state_next = ST_ON;
          w_cnt_next   = '0;
        end
      end
      default: begin
        if (r_cnt == SCAN_LAST) begin
          w_state_next = ST_DEAD;
          w_cnt_next   = '0;
          w_digit_next = r_digit + 2'd1;
          w_frame_end  = (r_digit == 2'd3);
        end
      end
    endcase
  end

  // The pending buffer is promoted only at the digit3 -> digit0 wrap. A
  // load offered in that same cycle lands in pending (which was empty) and
  // waits for the following wrap.
  assign w_load_accept    = load_valid && !r_pend_full;
  assign w_swap           = w_frame_end && r_pend_full;
  assign w_act_lz_next    = w_swap ? r_pend_lz : r_act_lz;
  assign w_pend_full_next = w_load_accept ? 1'b1 : (w_swap ? 1'b0 : r_pend_full);

  // Advance the scan sequencer every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_DEAD;
      r_digit <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_digit <= w_digit_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Track pending occupancy and present load_ready as a registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_full  <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_pend_full  <= w_pend_full_next;
      r_load_ready <= !w_pend_full_next;
    end
  end

  // Capture the blanking mode with the load, and promote it with the values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_lz <= 1'b0;
      r_act_lz  <= 1'b0;
    end else begin
      if (w_load_accept) begin
        r_pend_lz <= lz_blank;
      end
      r_act_lz <= w_act_lz_next;
    end
  end

  // Light the current digit's anode on every display while in ON.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode <= 4'b0000;
    end else if (w_state_next == ST_ON) begin
      r_anode <= 4'b0001 << w_digit_next;
    end else begin
      r_anode <= 4'b0000;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_disp
      logic [15:0] r_pend_val;
      logic [15:0] r_act_val;
      logic [15:0] w_act_val_next;
      logic [6:0]  r_seg;

      assign w_act_val_next = w_swap ? r_pend_val : r_act_val;

      // Hold the offered value in the pending buffer on a handshake.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pend_val <= '0;
        end else if (w_load_accept) begin
          r_pend_val <= w_in_val[gi];
        end
      end

      // Promote pending to active at a frame boundary.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_act_val <= '0;
        end else if (w_swap) begin
          r_act_val <= r_pend_val;
        end
      end

      // Re-load the segment bus only while heading into or staying in DEAD.
      // The decode uses the post-swap value, so the new frame's first digit
      // already shows during the boundary dead-time.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_seg <= 7'h00;
        end else if (w_state_next == ST_DEAD) begin
          r_seg <= f_digit_seg(w_act_val_next, w_act_lz_next, w_digit_next);
        end
      end

      assign w_seg[gi] = r_seg;
    end
  endgenerate

  assign load_ready          = r_load_ready;
  assign solar_anode_en      = r_anode;
  assign greenhouse_anode_en = r_anode;
  assign geothermal_anode_en = r_anode;
  assign solar_seg           = w_seg[0];
  assign greenhouse_seg      = w_seg[1];
  assign geothermal_seg      = w_seg[2];

endmodule
